mem_access_unit: RTL and testbench

- Initiator side of the word-addressed data-memory port. The pipeline's MEM stage issues byte, halfword and word loads and stores to this block.
- The block drives the memory's write-enable, word address and write data, and captures the combinational read data.
- Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
- Misaligned accesses are rejected without touching memory.

---
 rtl/mem_access_unit.sv | 111 +++++++++++
 tb/tb_mem_access_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator for a word-addressed data memory,
// with read-modify-write for sub-word stores and sign/zero-extended loads.
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, DONE} state_t;
  state_t            state_q, state_d;
  logic [1:0]        size_q, size_d, lane_q, lane_d;
  logic              sgn_q, sgn_d, err_q, err_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              misaligned;
  logic [4:0]        sh;
  logic [31:0]       lane_bits, mask, loaded, merged;
  logic              unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign misaligned = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign sh = {lane_q, 3'b000};
  assign lane_bits = mem_rdata >> sh;
  assign loaded = size_q == 2'b00 ? {{24{sgn_q & lane_bits[7]}}, lane_bits[7:0]} :
                  size_q == 2'b01 ? {{16{sgn_q & lane_bits[15]}}, lane_bits[15:0]} : mem_rdata;
  assign mask = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
  assign merged = (mem_rdata & ~mask) | (({16'h0, wdata_q} << sh) & mask);

  // data_q carries the word-store data, the merged word, or the load result; cleared in WRITE so stores respond with 0
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    lane_d  = lane_q;
    sgn_d   = sgn_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: if (req_valid) begin
        size_d  = req_size;
        lane_d  = req_addr[1:0];
        sgn_d   = req_signed;
        err_d   = misaligned;
        wdata_d = req_wdata[15:0];
        data_d  = (req_write && !misaligned) ? req_wdata : 32'h0;
        addr_d  = misaligned ? addr_q : req_addr[ADDR_W+1:2];
        state_d = misaligned ? DONE : !req_write ? LOAD : req_size == 2'b10 ? WRITE : MERGE;
      end
      LOAD: begin
        data_d  = loaded;
        state_d = DONE;
      end
      MERGE: begin
        data_d  = merged;
        state_d = WRITE;
      end
      WRITE: begin
        data_d  = 32'h0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 16'h0;
      data_q  <= 32'h0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == DONE;
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? data_q : 32'h0;
  assign mem_we     = state_q == WRITE;
  assign mem_wdata  = mem_we ? data_q : 32'h0;
  assign mem_addr   = addr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized load/store traffic checked against a
// byte-level reference memory and a per-request timing model.
module tb_mem_access_unit;
  localparam int AW = 10;
  logic clk = 0, reset = 0;
  logic req_valid = 0, req_write = 0, req_signed = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  int checks = 0, errors = 0, cyc = 0, resp_cnt = 0, we_cnt = 0;
  int ready_at = 0, resp_cyc = -1, we_cyc = -1, pend_cyc = 1 << 30;
  logic [31:0] exp_rdata = 0, exp_wdata = 0, last_rdata = 0;
  logic exp_err = 0, en = 0;
  logic [AW-1:0] exp_addr = 0, pend_addr = 0;

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: byte-wise memory view, alignment as "offset divisible by access size"
  task automatic accept_model(input logic w, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd);
    int wa, bo, n, lat;
    logic [7:0] b [4];
    logic [63:0] v;
    logic err;
    wa  = int'(a[AW+1:2]);
    bo  = int'(a[1:0]);
    n   = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    err = sz == 2'd3 || (bo % n) != 0;
    lat = err ? 1 : (!w || n == 4) ? 2 : 3;
    for (int i = 0; i < 4; i++) b[i] = ref_mem[wa][8*i +: 8];
    v = 0;
    if (!err && !w) begin
      for (int i = 0; i < n; i++) v = v + (64'(b[bo+i]) << (8*i));
      if (sg && v >= (64'd1 << (8*n-1))) v = v - (64'd1 << (8*n));
    end
    if (!err && w) begin
      for (int i = 0; i < n; i++) b[bo+i] = wd[8*i +: 8];
      ref_mem[wa] = {b[3], b[2], b[1], b[0]};
      exp_wdata = ref_mem[wa];
      we_cyc = cyc + lat - 1;
    end
    exp_rdata = v[31:0];
    exp_err   = err;
    resp_cyc  = cyc + lat;
    ready_at  = cyc + lat + 1;
    if (!err) begin
      pend_addr = a[AW+1:2];
      pend_cyc  = cyc + 1;
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 20), 32'd1);
    accept_model(w, sz, sg, a, wd);
    @(negedge clk);
    req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic idle(input int n);
    req_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (en) begin
      if (cyc >= pend_cyc) exp_addr = pend_addr;
      chk("req_ready", 32'(req_ready), 32'(cyc >= ready_at));
      chk("resp_valid", 32'(resp_valid), 32'(cyc == resp_cyc));
      if (cyc == resp_cyc) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
      end
      chk("mem_we", 32'(mem_we), 32'(cyc == we_cyc));
      if (cyc == we_cyc || cyc >= resp_cyc)
        chk("mem_wdata", mem_wdata, cyc == we_cyc ? exp_wdata : 32'h0);
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
    end
    if (resp_valid) begin
      last_rdata = resp_rdata;
      resp_cnt++;
    end
    if (mem_we) we_cnt++;
  end

  initial begin
    int r0, w0, ndiff;
    logic [31:0] old, a;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'h80F07F01; ref_mem[0] = 32'h80F07F01;
    mem[1] = 32'h11223344; ref_mem[1] = 32'h11223344;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1;
    en = 1;
    @(negedge clk);

    issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF); idle(4);
    chk("word_store_mem", mem[4], 32'hDEADBEEF);
    issue(0, 2'd2, 0, 32'h10, 32'h0); idle(4);
    chk("word_load", last_rdata, 32'hDEADBEEF);
    issue(1, 2'd0, 0, 32'h06, 32'h000000AA); idle(4);
    chk("byte_rmw_mem", mem[1], 32'h11AA3344);
    issue(0, 2'd0, 1, 32'h02, 32'h0); idle(3);
    chk("lb_signed", last_rdata, 32'hFFFFFFF0);
    issue(0, 2'd0, 0, 32'h02, 32'h0); idle(3);
    chk("lb_unsigned", last_rdata, 32'h000000F0);
    issue(0, 2'd1, 1, 32'h02, 32'h0); idle(3);
    chk("lh_signed_hi", last_rdata, 32'hFFFF80F0);
    issue(0, 2'd1, 1, 32'h00, 32'h0); idle(3);
    chk("lh_signed_lo", last_rdata, 32'h00007F01);

    w0 = we_cnt;
    issue(0, 2'd1, 0, 32'h03, 32'h0); idle(2);
    issue(1, 2'd2, 0, 32'h02, 32'h12345678); idle(2);
    issue(1, 2'd3, 0, 32'h00, 32'h12345678); idle(2);
    chk("err_no_write", 32'(we_cnt - w0), 32'd0);
    chk("err_mem_intact", mem[0], 32'h80F07F01);

    r0 = resp_cnt;
    issue(1, 2'd1, 0, 32'h22, 32'h0000BEEF);
    issue(0, 2'd2, 0, 32'h20, 32'h0);
    issue(0, 2'd0, 1, 32'h23, 32'h0);
    idle(6);
    chk("b2b_resp_count", 32'(resp_cnt - r0), 32'd3);

    old = ref_mem[2];
    req_write = 1; req_size = 2'd0; req_signed = 0; req_addr = 32'h08;
    req_wdata = {24'h0, ~old[7:0]}; req_valid = 1;
    en = 0;
    @(negedge clk);
    req_valid = 0;
    r0 = resp_cnt;
    w0 = we_cnt;
    reset = 0;
    #1;
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    reset = 1;
    repeat (4) @(negedge clk);
    chk("midrst_no_resp", 32'(resp_cnt - r0), 32'd0);
    chk("midrst_no_write", 32'(we_cnt - w0), 32'd0);
    chk("midrst_mem", mem[2], old);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    exp_addr = 0; pend_cyc = 1 << 30; resp_cyc = -1; we_cyc = -1; ready_at = 0;
    en = 1;
    issue(0, 2'd2, 0, 32'h08, 32'h0); idle(4);
    chk("midrst_reload", last_rdata, old);

    repeat (300) begin
      a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
      issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(6);

    ndiff = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) ndiff++;
    chk("final_mem_diff", 32'(ndiff), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
